// File: rtl/bomb_controller_if.sv
// Player-to-bomb bundle: frame timing, key requests and sprite position in;
// latched bomb position and FSM status out to the colour mapper.
interface bomb_controller_if;
  logic       frame_tick;
  logic       place;
  logic       chain;
  logic [9:0] userX;
  logic [9:0] userY;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic [9:0] bombS;
  logic       bomb_vis;
  logic       exploding;
  logic       explode_pulse;
  logic       ready;
  logic [7:0] fuse_left;

  modport master (
    output frame_tick, place, chain, userX, userY,
    input  bombX, bombY, bombS, bomb_vis, exploding, explode_pulse, ready, fuse_left
  );

  modport slave (
    input  frame_tick, place, chain, userX, userY,
    output bombX, bombY, bombS, bomb_vis, exploding, explode_pulse, ready, fuse_left
  );
endinterface

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place on a key edge, burn a frame-counted fuse,
// display the blast, then enforce a cooldown before the next placement.
module bomb_controller #(
  parameter int unsigned FUSE_FRAMES     = 120,
  parameter int unsigned BLAST_FRAMES    = 30,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  bomb_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, COOLDOWN} state_t;

  localparam logic [7:0] FUSE_CNT  = 8'(FUSE_FRAMES);
  localparam logic [7:0] BLAST_CNT = 8'(BLAST_FRAMES);
  localparam logic [7:0] COOL_CNT  = 8'(COOLDOWN_FRAMES);
  localparam logic [9:0] X_MAX     = 10'd624;
  localparam logic [9:0] Y_MAX     = 10'd464;

  // Snap to the 16-pixel grid, then keep the sprite fully on screen.
  function automatic logic [9:0] snap_clamp(input logic [9:0] pos, input logic [9:0] lim);
    logic [9:0] snapped;
    snapped = pos & 10'h3F0;
    return (snapped > lim) ? lim : snapped;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] bomb_x_q, bomb_x_d;
  logic [9:0] bomb_y_q, bomb_y_d;
  logic       place_q;
  logic       pulse_q, pulse_d;
  logic       place_evt;

  assign place_evt = bus.place & ~place_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bomb_x_q <= 10'd0;
      bomb_y_q <= 10'd0;
      place_q  <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      place_q  <= bus.place;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (place_evt) begin
          state_d  = ARMED;
          cnt_d    = FUSE_CNT;
          bomb_x_d = snap_clamp(bus.userX, X_MAX);
          bomb_y_d = snap_clamp(bus.userY, Y_MAX);
        end
      end
      ARMED: begin
        // A chained detonation swallows any coincident tick.
        if (bus.chain || (bus.frame_tick && cnt_q <= 8'd1)) begin
          state_d = EXPLODE;
          cnt_d   = BLAST_CNT;
          pulse_d = 1'b1;
        end else if (bus.frame_tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      EXPLODE: begin
        if (bus.frame_tick) begin
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = COOL_CNT;
          end
        end
      end
      COOLDOWN: begin
        if (bus.frame_tick) begin
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign bus.bombX         = bomb_x_q;
  assign bus.bombY         = bomb_y_q;
  assign bus.bombS         = 10'd17;
  assign bus.bomb_vis      = (state_q == ARMED) || (state_q == EXPLODE);
  assign bus.exploding     = (state_q == EXPLODE);
  assign bus.explode_pulse = pulse_q;
  assign bus.ready         = (state_q == IDLE);
  assign bus.fuse_left     = (state_q == ARMED) ? cnt_q : 8'd0;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller: a short-fuse instance for the lifecycle
// and a 100-frame-fuse instance for the chain case.
module tb_bomb_controller;
  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  bomb_controller_if f();
  bomb_controller_if g();

  bomb_controller #(.FUSE_FRAMES(3), .BLAST_FRAMES(2), .COOLDOWN_FRAMES(2)) dut (
    .Clk(Clk), .Reset(Reset), .bus(f.slave));

  bomb_controller #(.FUSE_FRAMES(100), .BLAST_FRAMES(2), .COOLDOWN_FRAMES(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(g.slave));

  task automatic pulse_tick();
    f.frame_tick = 1'b1;
    g.frame_tick = 1'b1;
    @(negedge Clk);
    f.frame_tick = 1'b0;
    g.frame_tick = 1'b0;
  endtask

  task automatic pulse_place();
    f.place = 1'b1;
    @(negedge Clk);
    f.place = 1'b0;
    @(negedge Clk);
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 20 && f.ready !== 1'b1; i++) pulse_tick();
    n_cmp++; if (f.ready !== 1'b1) begin n_fail++; $display("FAIL idle_timeout ready=%0b want=1", f.ready); end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    f.place = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++; if (f.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b want=1", f.ready); end
    n_cmp++; if (f.bomb_vis !== 1'b0) begin n_fail++; $display("FAIL rst_vis got=%0b want=0", f.bomb_vis); end
    n_cmp++; if (f.exploding !== 1'b0) begin n_fail++; $display("FAIL rst_exploding got=%0b want=0", f.exploding); end
    n_cmp++; if (f.explode_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got=%0b want=0", f.explode_pulse); end
    n_cmp++; if (f.fuse_left !== 8'd0) begin n_fail++; $display("FAIL rst_fuse got=%0d want=0", f.fuse_left); end
    n_cmp++; if (f.bombX !== 10'd0 || f.bombY !== 10'd0) begin n_fail++; $display("FAIL rst_pos got=%0d,%0d want=0,0", f.bombX, f.bombY); end
    n_cmp++; if (f.bombS !== 10'd17) begin n_fail++; $display("FAIL bombS got=%0d want=17", f.bombS); end
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++; if (f.ready !== 1'b1) begin n_fail++; $display("FAIL rst_held_place ready=%0b want=1", f.ready); end
    f.place = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_normal_cycle();
    f.userX = 10'd100;
    f.userY = 10'd50;
    pulse_place();
    n_cmp++; if (f.bombX !== 10'd96 || f.bombY !== 10'd48) begin n_fail++; $display("FAIL norm_pos got=%0d,%0d want=96,48", f.bombX, f.bombY); end
    n_cmp++; if (f.bomb_vis !== 1'b1 || f.ready !== 1'b0) begin n_fail++; $display("FAIL norm_armed vis=%0b ready=%0b want=1,0", f.bomb_vis, f.ready); end
    n_cmp++; if (f.fuse_left !== 8'd3) begin n_fail++; $display("FAIL norm_fuse3 got=%0d want=3", f.fuse_left); end
    pulse_tick();
    n_cmp++; if (f.fuse_left !== 8'd2) begin n_fail++; $display("FAIL norm_fuse2 got=%0d want=2", f.fuse_left); end
    pulse_tick();
    n_cmp++; if (f.fuse_left !== 8'd1) begin n_fail++; $display("FAIL norm_fuse1 got=%0d want=1", f.fuse_left); end
    pulse_tick();
    n_cmp++; if (f.exploding !== 1'b1 || f.explode_pulse !== 1'b1) begin n_fail++; $display("FAIL norm_explode exp=%0b pulse=%0b want=1,1", f.exploding, f.explode_pulse); end
    n_cmp++; if (f.fuse_left !== 8'd0 || f.bomb_vis !== 1'b1) begin n_fail++; $display("FAIL norm_explode_out fuse=%0d vis=%0b want=0,1", f.fuse_left, f.bomb_vis); end
    @(negedge Clk);
    n_cmp++; if (f.explode_pulse !== 1'b0 || f.exploding !== 1'b1) begin n_fail++; $display("FAIL norm_pulse_len pulse=%0b exp=%0b want=0,1", f.explode_pulse, f.exploding); end
    pulse_tick();
    n_cmp++; if (f.exploding !== 1'b1) begin n_fail++; $display("FAIL norm_blast1 exp=%0b want=1", f.exploding); end
    pulse_tick();
    n_cmp++; if (f.exploding !== 1'b0 || f.bomb_vis !== 1'b0 || f.ready !== 1'b0) begin n_fail++; $display("FAIL norm_cooldown exp=%0b vis=%0b ready=%0b want=0,0,0", f.exploding, f.bomb_vis, f.ready); end
    pulse_tick();
    n_cmp++; if (f.ready !== 1'b0) begin n_fail++; $display("FAIL norm_cool1 ready=%0b want=0", f.ready); end
    pulse_tick();
    n_cmp++; if (f.ready !== 1'b1) begin n_fail++; $display("FAIL norm_idle ready=%0b want=1", f.ready); end
    pulse_tick();
    n_cmp++; if (f.ready !== 1'b1 || f.fuse_left !== 8'd0) begin n_fail++; $display("FAIL idle_tick ready=%0b fuse=%0d want=1,0", f.ready, f.fuse_left); end
    n_cmp++; if (f.bombX !== 10'd96 || f.bombY !== 10'd48) begin n_fail++; $display("FAIL idle_hold_pos got=%0d,%0d want=96,48", f.bombX, f.bombY); end
  endtask

  task automatic test_clamp();
    f.userX = 10'd635; f.userY = 10'd470;
    pulse_place();
    n_cmp++; if (f.bombX !== 10'd624 || f.bombY !== 10'd464) begin n_fail++; $display("FAIL clamp_edge got=%0d,%0d want=624,464", f.bombX, f.bombY); end
    run_to_idle();
    f.userX = 10'd17; f.userY = 10'd33;
    pulse_place();
    n_cmp++; if (f.bombX !== 10'd16 || f.bombY !== 10'd32) begin n_fail++; $display("FAIL snap_small got=%0d,%0d want=16,32", f.bombX, f.bombY); end
    run_to_idle();
    f.userX = 10'd1000; f.userY = 10'd1000;
    pulse_place();
    n_cmp++; if (f.bombX !== 10'd624 || f.bombY !== 10'd464) begin n_fail++; $display("FAIL clamp_far got=%0d,%0d want=624,464", f.bombX, f.bombY); end
    run_to_idle();
  endtask

  task automatic test_ignored_place();
    f.userX = 10'd40; f.userY = 10'd40;
    pulse_place();
    f.userX = 10'd300; f.userY = 10'd300;
    pulse_place();
    n_cmp++; if (f.fuse_left !== 8'd3 || f.bombX !== 10'd32 || f.bombY !== 10'd32) begin n_fail++; $display("FAIL ign_armed fuse=%0d pos=%0d,%0d want=3,32,32", f.fuse_left, f.bombX, f.bombY); end
    pulse_tick(); pulse_tick(); pulse_tick();
    pulse_place();
    n_cmp++; if (f.exploding !== 1'b1 || f.bombX !== 10'd32) begin n_fail++; $display("FAIL ign_explode exp=%0b x=%0d want=1,32", f.exploding, f.bombX); end
    pulse_tick(); pulse_tick();
    pulse_place();
    n_cmp++; if (f.ready !== 1'b0 || f.bomb_vis !== 1'b0) begin n_fail++; $display("FAIL ign_cooldown ready=%0b vis=%0b want=0,0", f.ready, f.bomb_vis); end
    f.place = 1'b1;
    pulse_tick(); pulse_tick();
    @(negedge Clk); @(negedge Clk);
    n_cmp++; if (f.ready !== 1'b1) begin n_fail++; $display("FAIL held_no_arm ready=%0b want=1", f.ready); end
    f.place = 1'b0;
    @(negedge Clk);
    f.place = 1'b1;
    @(negedge Clk);
    n_cmp++; if (f.fuse_left !== 8'd3 || f.bombX !== 10'd288) begin n_fail++; $display("FAIL fresh_edge fuse=%0d x=%0d want=3,288", f.fuse_left, f.bombX); end
    f.place = 1'b0;
    run_to_idle();
  endtask

  task automatic test_collision();
    @(negedge Clk);
    f.place = 1'b1;
    f.frame_tick = 1'b1;
    @(negedge Clk);
    f.place = 1'b0;
    f.frame_tick = 1'b0;
    n_cmp++; if (f.fuse_left !== 8'd3) begin n_fail++; $display("FAIL collision fuse=%0d want=3", f.fuse_left); end
    run_to_idle();
  endtask

  task automatic test_chain();
    g.chain = 1'b1;
    @(negedge Clk);
    g.chain = 1'b0;
    n_cmp++; if (g.ready !== 1'b1) begin n_fail++; $display("FAIL chain_idle ready=%0b want=1", g.ready); end
    g.userX = 10'd100; g.userY = 10'd50;
    g.place = 1'b1;
    @(negedge Clk);
    g.place = 1'b0;
    n_cmp++; if (g.fuse_left !== 8'd100) begin n_fail++; $display("FAIL chain_arm fuse=%0d want=100", g.fuse_left); end
    g.chain = 1'b1; f.frame_tick = 1'b1; g.frame_tick = 1'b1;
    @(negedge Clk);
    g.chain = 1'b0; f.frame_tick = 1'b0; g.frame_tick = 1'b0;
    n_cmp++; if (g.exploding !== 1'b1 || g.explode_pulse !== 1'b1 || g.fuse_left !== 8'd0) begin n_fail++; $display("FAIL chain_explode exp=%0b pulse=%0b fuse=%0d want=1,1,0", g.exploding, g.explode_pulse, g.fuse_left); end
    pulse_tick();
    n_cmp++; if (g.exploding !== 1'b1) begin n_fail++; $display("FAIL chain_tick_uncounted exp=%0b want=1", g.exploding); end
    pulse_tick();
    n_cmp++; if (g.exploding !== 1'b0 || g.ready !== 1'b0) begin n_fail++; $display("FAIL chain_cooldown exp=%0b ready=%0b want=0,0", g.exploding, g.ready); end
    pulse_tick(); pulse_tick();
    n_cmp++; if (g.ready !== 1'b1) begin n_fail++; $display("FAIL chain_idle_end ready=%0b want=1", g.ready); end
  endtask

  task automatic test_async_reset();
    f.userX = 10'd200; f.userY = 10'd100;
    pulse_place();
    pulse_tick(); pulse_tick(); pulse_tick();
    n_cmp++; if (f.exploding !== 1'b1 || f.explode_pulse !== 1'b1) begin n_fail++; $display("FAIL arst_pre exp=%0b pulse=%0b want=1,1", f.exploding, f.explode_pulse); end
    #2;
    Reset = 1'b1;
    f.place = 1'b1;
    #1;
    n_cmp++; if (f.exploding !== 1'b0 || f.explode_pulse !== 1'b0 || f.bomb_vis !== 1'b0) begin n_fail++; $display("FAIL arst_async exp=%0b pulse=%0b vis=%0b want=0,0,0", f.exploding, f.explode_pulse, f.bomb_vis); end
    n_cmp++; if (f.ready !== 1'b1 || f.bombX !== 10'd0 || f.bombY !== 10'd0) begin n_fail++; $display("FAIL arst_async_out ready=%0b pos=%0d,%0d want=1,0,0", f.ready, f.bombX, f.bombY); end
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++; if (f.ready !== 1'b1 || f.fuse_left !== 8'd0 || f.explode_pulse !== 1'b0) begin n_fail++; $display("FAIL arst_held_place ready=%0b fuse=%0d pulse=%0b want=1,0,0", f.ready, f.fuse_left, f.explode_pulse); end
    f.place = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    f.frame_tick = 1'b0; f.place = 1'b0; f.chain = 1'b0; f.userX = 10'd0; f.userY = 10'd0;
    g.frame_tick = 1'b0; g.place = 1'b0; g.chain = 1'b0; g.userX = 10'd0; g.userY = 10'd0;
    test_reset();
    test_normal_cycle();
    test_clamp();
    test_ignored_place();
    test_collision();
    test_chain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bomb_controller.md
BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter FUSE_FRAMES, default 120, number of frame_tick pulses from placement to detonation (legal range 1..255).
REQ-002 Parameter BLAST_FRAMES, default 30, number of frame_tick pulses the explosion is displayed (legal range 1..255).
REQ-003 Parameter COOLDOWN_FRAMES, default 15, number of frame_tick pulses before a new bomb may be placed (legal range 1..255).
REQ-004 Clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-005 Reset  input  1  reset, asynchronous and active-high.
REQ-006 frame_tick  input  1  one-Clk-cycle pulse, once per video frame.
REQ-007 place  input  1  level request from the player's keypress; edge-detected internally.
REQ-008 chain  input  1  another explosion covers this bomb; forces early detonation.
REQ-009 userX, userY  input  10 each  player sprite top-left pixel position.
REQ-010 bombX, bombY  output  10 each  latched, grid-snapped bomb top-left position for the colour mapper.
REQ-011 bombS  output  10  bomb sprite size; constant 10'd17.
REQ-012 bomb_vis  output  1  high in ARMED and EXPLODE; gates the bomb sprite in the colour mapper.
REQ-013 exploding  output  1  high in EXPLODE only.
REQ-014 explode_pulse  output  1  single-cycle pulse on the first Clk cycle in EXPLODE.
REQ-015 ready  output  1  high in IDLE only.
REQ-016 fuse_left  output  8  remaining fuse count in ARMED, 0 in every other state.

Function
REQ-017 FSM states SHALL be IDLE, ARMED, EXPLODE and COOLDOWN; all outputs except bombS SHALL be registered or decoded directly from the state and counter registers.
REQ-018 place_q SHALL register place each cycle; a placement event SHALL be place=1 with place_q=0.
REQ-019 IDLE to ARMED on a placement event: next cycle the counter = FUSE_FRAMES; bombX = {userX[9:4],4'b0000}, clamped to 624; bombY = {userY[9:4],4'b0000}, clamped to 464.
REQ-020 In every non-IDLE state, a frame_tick with counter>1 SHALL decrement the counter; a frame_tick with counter==1 SHALL advance the state and load the next state's count.
REQ-021 ARMED to EXPLODE after FUSE_FRAMES ticks; EXPLODE SHALL load the counter with BLAST_FRAMES.
REQ-022 EXPLODE to COOLDOWN after BLAST_FRAMES ticks; COOLDOWN SHALL load the counter with COOLDOWN_FRAMES.
REQ-023 COOLDOWN to IDLE after COOLDOWN_FRAMES ticks; the counter SHALL go to 0.
REQ-024 chain=1 in ARMED SHALL go to EXPLODE on the next cycle regardless of the counter; chain SHALL be ignored in every other state.
REQ-025 Simultaneous chain and frame_tick in ARMED: chain wins, and the tick SHALL NOT be counted in EXPLODE.
REQ-026 Simultaneous placement event and frame_tick in IDLE: placement wins, the counter loads FUSE_FRAMES, and that tick SHALL NOT be counted.
REQ-027 Placement events outside IDLE SHALL be discarded and not queued.
REQ-028 Holding place high from COOLDOWN into IDLE SHALL NOT arm; a fresh 0-to-1 edge is required.
REQ-029 bombX and bombY SHALL hold their value from placement until the next placement, including through IDLE.
REQ-030 frame_tick with no state change SHALL have no effect in IDLE.

Reset
REQ-031 Reset=1 SHALL immediately force: state IDLE, counter 0, bombX=bombY=0, place_q=1, bomb_vis=0, exploding=0, explode_pulse=0, ready=1, fuse_left=0.
REQ-032 place_q resetting to 1 SHALL mean a place held high through reset does not arm.
REQ-033 Reset asserted mid-operation in any state SHALL abandon that bomb with no explode_pulse.

Verification
REQ-034 Normal cycle: FUSE=3, BLAST=2, COOLDOWN=2; userX=100, userY=50; pulse place -> bombX=96, bombY=48, bomb_vis=1, fuse_left 3,2,1; on the 3rd tick exploding=1 and explode_pulse lasts 1 cycle; 2 ticks later COOLDOWN; 2 ticks later ready=1.
REQ-035 Clamp: userX=635, userY=470, place -> bombX=624, bombY=464.
REQ-036 Chain: ARMED with fuse_left=100, chain=1 and frame_tick in the same cycle -> EXPLODE next cycle, and exactly BLAST_FRAMES further ticks to COOLDOWN.
REQ-037 Ignored and held requests: place pulses in ARMED, EXPLODE and COOLDOWN -> no state effect; place held high into IDLE -> stays IDLE until place goes 0 then 1.
REQ-038 Collision: placement and frame_tick in the same IDLE cycle -> fuse_left=FUSE_FRAMES, not FUSE_FRAMES-1.
REQ-039 Reset: async Reset in EXPLODE between Clk edges -> outputs reach their reset values before the next edge; place held high during reset does not arm.
